// File: rtl/axi_arb_pkg.sv
// Shared state type and constants for the packet round-robin arbiter.
package axi_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCK
    } arb_state_t;

    localparam int NUM_CH_DEF     = 4;
    localparam int DATA_WIDTH_DEF = 128;
    localparam int CH_W_DEF       = $clog2(NUM_CH_DEF);

    // Adder output channels mapped onto arbiter source indices
    localparam int CH00 = 0;
    localparam int CH01 = 1;
    localparam int CH20 = 2;
    localparam int CH21 = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting index above last_grant, wrapping.
module rr_priority_picker #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   next_idx,
    output logic              any_req
);

    logic            found;
    int              pos;
    logic [CH_W-1:0] cand;

    // Offset k=NUM_CH revisits last_grant itself, so a lone requester always wins
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        pos      = 0;
        cand     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            pos  = (int'(last_grant) + k) % NUM_CH;
            cand = CH_W'(pos);
            if (!found && req[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axi_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_CH streams into one channel-tagged stream.
// Optional macro ARB_TIMEOUT_EN: force release of a grant whose source stalls mid-packet.
module axi_packet_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int CH_W           = $clog2(NUM_CH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
    output logic [CH_W-1:0]              m_chan,
    output logic                         busy,
    output logic                         timeout_err
);

    arb_state_t      state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] next_grant;
    logic            any_req;
    logic            grant_ready;
    logic            accept;
    logic            stall_expired;

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .req        (s_valid),
        .last_grant (last_grant),
        .next_idx   (next_grant),
        .any_req    (any_req)
    );

    assign grant_ready = (state == LOCK) && (!m_valid || m_ready);
    assign accept      = s_valid[grant] && grant_ready;
    assign busy        = (state == LOCK);

    always_comb begin
        s_ready        = '0;
        s_ready[grant] = grant_ready;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_cnt;

    assign stall_expired = (state == LOCK) && !s_valid[grant]
                         && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= stall_expired;
            if ((state != LOCK) || s_valid[grant] || stall_expired)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign stall_expired      = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Output fields are only rewritten on accept, so they stay stable while downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_chan     <= '0;
        end else begin
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data[grant*DATA_WIDTH +: DATA_WIDTH];
                        m_last  <= s_last[grant];
                        m_chan  <= grant;
                        if (s_last[grant]) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end else if (stall_expired) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_packet_rr_arbiter.sv
// Directed testbench for axi_packet_rr_arbiter; timeout scenarios run only with ARB_TIMEOUT_EN.
module tb_axi_packet_rr_arbiter;
    import axi_arb_pkg::*;

    localparam int NCH = NUM_CH_DEF;
    localparam int DW  = DATA_WIDTH_DEF;
    localparam int CW  = CH_W_DEF;
`ifdef ARB_TIMEOUT_EN
    localparam int TOUT        = 8;
    localparam int DROP_CYCLES = 5;
`else
    localparam int TOUT        = 256;
    localparam int DROP_CYCLES = 10;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    s_valid;
    logic [NCH-1:0]    s_ready;
    logic [NCH*DW-1:0] s_data;
    logic [NCH-1:0]    s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [CW-1:0]     m_chan;
    logic              busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    int beat_sent [NCH];
    int pkt_len   [NCH];
    bit drop      [NCH];

    always #5 clock = ~clock;

    axi_packet_rr_arbiter #(
        .NUM_CH         (NCH),
        .DATA_WIDTH     (DW),
        .CH_W           (CW),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_chan      (m_chan),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Beat payload 0xA<ch><beat>: never zero, so it cannot match the reset value
    function automatic logic [DW-1:0] exp_data(input int ch, input int beat);
        return DW'(32'hA000 + ch * 256 + beat);
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < NCH; i++) begin
            s_valid[i]         = (beat_sent[i] < pkt_len[i]) && !drop[i];
            s_last[i]          = (beat_sent[i] == pkt_len[i] - 1);
            s_data[i*DW +: DW] = exp_data(i, beat_sent[i]);
        end
    endtask

    task automatic advance(input logic [NCH-1:0] acc);
        @(posedge clock);
        #1;
        for (int i = 0; i < NCH; i++)
            if (acc[i]) beat_sent[i]++;
        drive_sources();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            beat_sent[i] = 0;
            pkt_len[i]   = 0;
            drop[i]      = 1'b0;
        end
        drive_sources();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] acc;
        reset   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            beat_sent[i] = 0;
            pkt_len[i]   = 1;
            drop[i]      = 1'b0;
        end
        drive_sources();
        @(posedge clock);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({m_valid, m_last, busy, timeout_err, s_ready, m_chan} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_ctrl: got %b want 0", {m_valid, m_last, busy, timeout_err, s_ready, m_chan});
            end
            checks++;
            if (m_data !== '0) begin
                failures++;
                $display("[TB] FAIL reset_data: got %0h want 0", m_data);
            end
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (s_ready !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_ready: got s_ready=%b busy=%b want 0000/0", s_ready, busy);
        end
        acc = s_valid & s_ready;
        advance(acc);
        @(negedge clock);
        checks++;
        if (s_ready !== 4'b0001 || busy !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_grant: got s_ready=%b busy=%b m_valid=%b want 0001/1/0", s_ready, busy, m_valid);
        end
        acc = s_valid & s_ready;
        advance(acc);
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b1 || m_chan !== CW'(CH00) || m_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_beat: got v=%b ch=%0d last=%b want 1/0/1", m_valid, m_chan, m_last);
        end
        checks++;
        if (m_data !== exp_data(CH00, 0)) begin
            failures++;
            $display("[TB] FAIL first_data: got %0h want %0h", m_data, exp_data(CH00, 0));
        end
        checks++;
        if (busy !== 1'b0 || s_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_beat_release: got busy=%b s_ready=%b want 0/0000", busy, s_ready);
        end
        acc = s_valid & s_ready;
        advance(acc);
        @(negedge clock);
        checks++;
        if (s_ready !== 4'b0010 || m_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL second_grant: got s_ready=%b m_valid=%b busy=%b want 0010/0/1", s_ready, m_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] acc;
        int n;
        int prev_last;
        int ech;
        int ebeat;
        do_reset();
        for (int i = 0; i < NCH; i++) pkt_len[i] = 3;
        drive_sources();
        n         = 0;
        prev_last = -1;
        for (int cyc = 0; cyc < 80 && n < 12; cyc++) begin
            @(negedge clock);
            checks++;
            if ($countones(s_ready) > 1) begin
                failures++;
                $display("[TB] FAIL onehot_ready: got %b want at most one bit", s_ready);
            end
            if (m_valid) begin
                ech   = n / 3;
                ebeat = n % 3;
                if (n == 0) begin
                    checks++;
                    if (cyc != 2) begin
                        failures++;
                        $display("[TB] FAIL first_latency: got cycle %0d want 2", cyc);
                    end
                end
                checks++;
                if (m_chan !== CW'(ech) || m_data !== exp_data(ech, ebeat) || m_last !== (ebeat == 2)) begin
                    failures++;
                    $display("[TB] FAIL rr_beat%0d: got ch=%0d data=%0h last=%b want ch=%0d data=%0h last=%b",
                             n, m_chan, m_data, m_last, ech, exp_data(ech, ebeat), ebeat == 2);
                end
                n++;
            end
            acc = s_valid & s_ready;
            for (int i = 0; i < NCH; i++) begin
                if (acc[i]) begin
                    if (beat_sent[i] == 0 && prev_last >= 0) begin
                        checks++;
                        if (cyc - prev_last != 2) begin
                            failures++;
                            $display("[TB] FAIL packet_gap ch%0d: got %0d want 2", i, cyc - prev_last);
                        end
                    end
                    if (beat_sent[i] == 2) prev_last = cyc;
                end
            end
            advance(acc);
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("[TB] FAIL rr_beat_count: got %0d want 12", n);
        end
    endtask

    task automatic test_backpressure();
        logic [NCH-1:0] acc;
        logic [DW-1:0]  held;
        bit             stalled;
        int             n;
        do_reset();
        pkt_len[CH20] = 4;
        drive_sources();
        n       = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            m_ready = (cyc % 2 == 0);
            @(negedge clock);
            if (stalled) begin
                checks++;
                if (m_data !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got %0h want %0h", m_data, held);
                end
            end
            stalled = 1'b0;
            if (m_valid && !m_ready) begin
                checks++;
                if (s_ready !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL stall_ready: got %b want 0000", s_ready);
                end
                held    = m_data;
                stalled = 1'b1;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_chan !== CW'(CH20) || m_data !== exp_data(CH20, n) || m_last !== (n == 3)) begin
                    failures++;
                    $display("[TB] FAIL bp_beat%0d: got ch=%0d data=%0h last=%b want ch=2 data=%0h last=%b",
                             n, m_chan, m_data, m_last, exp_data(CH20, n), n == 3);
                end
                n++;
            end
            acc = s_valid & s_ready;
            advance(acc);
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d want 4", n);
        end
        m_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_dup: got m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_drop_mid_packet();
        logic [NCH-1:0] acc;
        int exp_ch   [6] = '{CH01, CH01, CH01, CH01, CH21, CH21};
        int exp_beat [6] = '{0, 1, 2, 3, 0, 1};
        int n;
        int drop_left;
        do_reset();
        pkt_len[CH01] = 4;
        pkt_len[CH21] = 2;
        drive_sources();
        n         = 0;
        drop_left = DROP_CYCLES;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            @(negedge clock);
            if (drop[CH01]) begin
                checks++;
                if (busy !== 1'b1 || s_ready[CH21] !== 1'b0 || timeout_err !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL drop_hold: got busy=%b s_ready3=%b terr=%b want 1/0/0", busy, s_ready[CH21], timeout_err);
                end
            end
            if (m_valid) begin
                checks++;
                if (m_chan !== CW'(exp_ch[n]) || m_data !== exp_data(exp_ch[n], exp_beat[n])) begin
                    failures++;
                    $display("[TB] FAIL drop_beat%0d: got ch=%0d data=%0h want ch=%0d data=%0h",
                             n, m_chan, m_data, exp_ch[n], exp_data(exp_ch[n], exp_beat[n]));
                end
                n++;
            end
            acc = s_valid & s_ready;
            advance(acc);
            if (drop[CH01]) begin
                drop_left--;
                if (drop_left == 0) drop[CH01] = 1'b0;
            end else if (beat_sent[CH01] == 2 && drop_left > 0) begin
                drop[CH01] = 1'b1;
            end
            drive_sources();
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("[TB] FAIL drop_count: got %0d want 6", n);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [NCH-1:0] acc;
        do_reset();
        pkt_len[CH01] = 1;
        drive_sources();
        for (int cyc = 0; cyc < 20 && beat_sent[CH01] < 1; cyc++) begin
            @(negedge clock);
            acc = s_valid & s_ready;
            advance(acc);
        end
        pkt_len[CH00] = 5;
        drive_sources();
        for (int cyc = 0; cyc < 20 && beat_sent[CH00] < 2; cyc++) begin
            @(negedge clock);
            acc = s_valid & s_ready;
            advance(acc);
        end
        checks++;
        if (beat_sent[CH00] != 2) begin
            failures++;
            $display("[TB] FAIL rst_setup: got %0d beats want 2", beat_sent[CH00]);
        end
        reset         = 1'b1;
        pkt_len[CH21] = 1;
        drive_sources();
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || s_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rst_truncate: got v=%b last=%b busy=%b s_ready=%b want 0/0/0/0000", m_valid, m_last, busy, s_ready);
        end
        @(posedge clock);
        #1;
        reset           = 1'b0;
        beat_sent[CH00] = 0;
        drive_sources();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (s_ready !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_regrant: got s_ready=%b busy=%b want 0001/1", s_ready, busy);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NCH-1:0] acc;
        int pulses;
        int pulse_cyc;
        int grant1_cyc;
        do_reset();
        pkt_len[CH00] = 4;
        pkt_len[CH01] = 1;
        drive_sources();
        for (int cyc = 0; cyc < 20 && beat_sent[CH00] < 2; cyc++) begin
            @(negedge clock);
            acc = s_valid & s_ready;
            advance(acc);
        end
        drop[CH00] = 1'b1;
        drive_sources();
        pulses     = 0;
        pulse_cyc  = -1;
        grant1_cyc = -1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clock);
            if (timeout_err) begin
                pulses++;
                pulse_cyc = cyc;
            end
            if (s_ready == 4'b0010 && grant1_cyc < 0) grant1_cyc = cyc;
            acc = s_valid & s_ready;
            advance(acc);
        end
        checks++;
        if (pulses != 1 || pulse_cyc != 8) begin
            failures++;
            $display("[TB] FAIL to_pulse: got %0d pulses at %0d want 1 at 8", pulses, pulse_cyc);
        end
        checks++;
        if (grant1_cyc != 9) begin
            failures++;
            $display("[TB] FAIL to_next_grant: got cycle %0d want 9", grant1_cyc);
        end

        do_reset();
        pkt_len[CH00] = 4;
        drive_sources();
        for (int cyc = 0; cyc < 20 && beat_sent[CH00] < 2; cyc++) begin
            @(negedge clock);
            acc = s_valid & s_ready;
            advance(acc);
        end
        drop[CH00] = 1'b1;
        drive_sources();
        pulses = 0;
        for (int cyc = 0; cyc < 30 && !(beat_sent[CH00] == 4 && !m_valid); cyc++) begin
            @(negedge clock);
            if (timeout_err) pulses++;
            acc = s_valid & s_ready;
            advance(acc);
            if (cyc == 6) begin
                drop[CH00] = 1'b0;
                drive_sources();
            end
        end
        checks++;
        if (pulses != 0 || beat_sent[CH00] != 4) begin
            failures++;
            $display("[TB] FAIL to_no_pulse: got %0d pulses %0d beats want 0/4", pulses, beat_sent[CH00]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_drop_mid_packet();
        test_reset_mid_packet();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_packet_rr_arbiter.md
Name: axi_packet_rr_arbiter

Overview:
- Merges the four per-channel output streams of the adder (channels 00, 01, 20, 21 → indices 0..3) onto one shared downstream stream.
- Arbitrates round-robin at packet granularity: a grant is held until the granted source's last beat is accepted.
- Tags every output beat with its source channel index so downstream framing and DMA can demultiplex.

Parameters:
- NUM_CH, 4, number of input streams.
- DATA_WIDTH, 128, width of each beat (16 samples × 8 b).
- CH_W, 2, channel index width, clog2(NUM_CH).
- TIMEOUT_CYCLES, 256, stall limit; used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  NUM_CH  per-source beat valid.
- s_ready  out  NUM_CH  per-source ready; at most one bit is high.
- s_data  in  NUM_CH*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_CH  per-source end of packet.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output beat.
- m_last  out  1  output end of packet.
- m_chan  out  CH_W  source index of the current beat.
- busy  out  1  high while a grant is held.
- timeout_err  out  1  one-cycle pulse on forced release (feature only).

Behaviour:
- Reset values:
  - m_valid=0, m_data=0, m_last=0, m_chan=0, s_ready=0, busy=0, timeout_err=0.
  - state=IDLE, last_grant=NUM_CH-1, so channel 0 wins first.
- States:
  - IDLE: if any s_valid is high, select the first set bit searching upward from last_grant+1 with wrap. Register that index as grant, go to LOCK. s_ready stays 0 in IDLE.
  - LOCK: s_ready[grant] = (~m_valid | m_ready); all other s_ready bits are 0. busy=1.
- Beat accept: a beat is accepted when s_valid[grant] & s_ready[grant]. On accept:
  - m_data <= s_data[grant], m_last <= s_last[grant], m_chan <= grant, m_valid <= 1.
- Accept of a beat with s_last=1: last_grant <= grant, state <= IDLE.
- Output drain: if m_valid & m_ready and no new accept this cycle, m_valid <= 0. m_data, m_last and m_chan hold their values.
- Output register: one stage, no bubble while streaming. Throughput is 1 beat/cycle within a packet.
- Latency:
  - From IDLE, s_valid high at cycle t gives grant at t+1, accept at t+1, and m_valid at t+2.
  - Back-to-back packets have exactly one idle arbitration cycle between them (s_ready low).
- Downstream stall: when m_valid=1 and m_ready=0, s_ready[grant]=0. Output beat fields are held stable.
- Granted source drops s_valid mid-packet: the grant is held and no other source is served. Without the feature, this stall is unbounded.
- Single-beat packet (s_last on the first beat): LOCK lasts one cycle, then IDLE.
- Simultaneous requests from all sources: service order is 0,1,2,3,0,... Each source gets one packet per round.
- A request arriving while another source is locked is not lost; it waits for the next arbitration.
- Reset mid-packet: the packet is truncated. The in-flight output beat is discarded (m_valid=0 the cycle after reset is sampled), and no m_last is emitted.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A stall counter increments in LOCK while s_valid[grant]=0, and clears on any cycle with s_valid[grant]=1.
  - On reaching TIMEOUT_CYCLES-1: state <= IDLE, last_grant <= grant, timeout_err pulses high for 1 cycle.
  - No synthetic m_last is generated.
- Not defined: no counter is built, timeout_err is tied to 0, and the grant is held indefinitely.

Decomposition:
- Package axi_arb_pkg holds:
  - the state enum {IDLE, LOCK};
  - NUM_CH_DEF=4, DATA_WIDTH_DEF=128, and CH_W derived via clog2;
  - the channel index constants CH00=0, CH01=1, CH20=2, CH21=3.
- Sub-module rr_priority_picker: combinational. Inputs are a request vector and last_grant; outputs are the next index and an any-request flag. It is instantiated once.

Test Plan:
- Reset held 3 cycles, with all s_valid=1 during reset → all outputs 0 during reset. After release, channel 0 is granted first: m_chan=0 at cycle 2 after release.
- All 4 sources send 3-beat packets (data = 0xCH_BEAT pattern), m_ready=1 → m_chan sequence 0,0,0,1,1,1,2,2,2,3,3,3. m_last set on beats 3, 6, 9, 12. One gap cycle between packets.
- Source 2 only, 4-beat packet, m_ready toggling 1,0,1,0 → no beat lost or duplicated. m_data held while m_ready=0. s_ready[2]=0 while the output is stalled.
- Source 1 locked, drops s_valid for 10 cycles mid-packet while source 3 is valid → source 3 is never granted until source 1's last beat. busy stays 1.
- Reset asserted on beat 2 of a 5-beat packet from source 0 → next cycle m_valid=0 and state IDLE. The next grant follows the reset order, so channel 0 is granted if still valid.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: granted source 0 stalls 8 cycles mid-packet → timeout_err is a single pulse and source 1 is granted next. Stalling 7 cycles then resuming → no pulse.
